// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: FSM encoding, opcodes and
// default widths.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int DEF_IN_W     = 4;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_ALU_WAIT = 1;
    localparam int DEF_CNT_W    = 16;

    // Settle counter width; ALU_WAIT is limited to 1..15.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. Grant is combinational; the last winner is
// remembered only when the caller reports that a grant was actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_grant;

    // Requester 1 wins when alone, or when both ask and 0 won last time.
    always_comb begin
        gnt_id = req[1] & (~req[0] | ~last_grant);
        gnt    = 2'b00;
        if (req != 2'b00) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin
// accept, registered ALU drive, settle wait, then a valid/ready response.
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int ALU_WAIT = DEF_ALU_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_sel,
    input  logic [IN_W-1:0]  req0_a,
    input  logic [IN_W-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_sel,
    input  logic [IN_W-1:0]  req1_a,
    input  logic [IN_W-1:0]  req1_b,
    output logic [1:0]       alu_sel,
    output logic [IN_W-1:0]  alu_a,
    output logic [IN_W-1:0]  alu_b,
    input  logic [OUT_W-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [OUT_W-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    if (ALU_WAIT < 1 || ALU_WAIT > 15) begin : g_bad_wait
        $error("alu_req_arbiter: ALU_WAIT must be in 1..15");
    end

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic              accept;
    logic              capture;
    logic              rsp_fire;

    // Grants only count in IDLE, so an in-flight op blocks new accepts.
    assign accept   = (state == ST_IDLE) && (req0_valid || req1_valid);
    assign capture  = (state == ST_EXEC) && (wait_cnt == WAIT_W'(1));
    assign rsp_fire = (state == ST_RESP) && rsp_ready;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)   state_nxt = ST_EXEC;
            ST_EXEC: if (capture)  state_nxt = ST_RESP;
            ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == ST_IDLE) && gnt[0];
        req1_ready = (state == ST_IDLE) && gnt[1];
        busy       = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            wait_cnt  <= '0;
            ops_done  <= '0;
        end else begin
            // ALU inputs change only on accept, so they are stable through EXEC.
            if (accept) begin
                alu_sel  <= gnt_id ? req1_sel : req0_sel;
                alu_a    <= gnt_id ? req1_a   : req0_a;
                alu_b    <= gnt_id ? req1_b   : req0_b;
                rsp_id   <= gnt_id;
                wait_cnt <= WAIT_W'(ALU_WAIT);
            end else if (state == ST_EXEC) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end

            if (capture) begin
                rsp_data  <= alu_out;
                rsp_valid <= 1'b1;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end

            if (rsp_fire && (ops_done != '1)) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench: directed test-plan scenarios plus random traffic
// against a cycle-count transaction model; a second instance covers long
// settle time and counter saturation.
module tb_alu_req_arbiter;
    import alu_ctrl_pkg::*;

    localparam int W_A = 1;
    localparam int W_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [7:0] alu_fn(logic [1:0] s, logic [3:0] x, logic [3:0] y);
        logic [7:0] xe, ye;
        xe = {4'b0, x};
        ye = {4'b0, y};
        case (s)
            OP_ADD:  return xe + ye;
            OP_SUB:  return xe - ye;
            OP_MUL:  return xe * ye;
            default: return xe & ye;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instance A: ALU_WAIT=1, 16-bit counter ----------------
    logic       a_rst_n, a_r0v, a_r1v, a_r0rdy, a_r1rdy;
    logic [1:0] a_r0s, a_r1s, a_alu_sel;
    logic [3:0] a_r0a, a_r0b, a_r1a, a_r1b, a_alu_a, a_alu_b;
    logic [7:0] a_alu_out, a_rsp_data;
    logic       a_rsp_valid, a_rsp_ready, a_rsp_id, a_busy;
    logic [15:0] a_ops;

    assign a_alu_out = alu_fn(a_alu_sel, a_alu_a, a_alu_b);

    alu_req_arbiter #(.IN_W(4), .OUT_W(8), .ALU_WAIT(W_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_r0v), .req0_ready(a_r0rdy), .req0_sel(a_r0s), .req0_a(a_r0a), .req0_b(a_r0b),
        .req1_valid(a_r1v), .req1_ready(a_r1rdy), .req1_sel(a_r1s), .req1_a(a_r1a), .req1_b(a_r1b),
        .alu_sel(a_alu_sel), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_out(a_alu_out),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_data(a_rsp_data), .busy(a_busy), .ops_done(a_ops)
    );

    // ---------------- instance B: ALU_WAIT=4, 2-bit counter ----------------
    logic       b_rst_n, b_r0v, b_r1v, b_r0rdy, b_r1rdy;
    logic [1:0] b_r0s, b_r1s, b_alu_sel;
    logic [3:0] b_r0a, b_r0b, b_r1a, b_r1b, b_alu_a, b_alu_b;
    logic [7:0] b_alu_out, b_rsp_data;
    logic       b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy;
    logic [1:0] b_ops;

    assign b_alu_out = alu_fn(b_alu_sel, b_alu_a, b_alu_b);

    alu_req_arbiter #(.IN_W(4), .OUT_W(8), .ALU_WAIT(W_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_sel(b_r0s), .req0_a(b_r0a), .req0_b(b_r0b),
        .req1_valid(b_r1v), .req1_ready(b_r1rdy), .req1_sel(b_r1s), .req1_a(b_r1a), .req1_b(b_r1b),
        .alu_sel(b_alu_sel), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_out(b_alu_out),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_data(b_rsp_data), .busy(b_busy), .ops_done(b_ops)
    );

    // Transaction model for instance A: one op in flight, tracked by the
    // cycle number at which its result becomes visible.
    bit         m_busy, m_rvalid, m_last, m_id;
    logic [1:0] m_sel;
    logic [3:0] m_a, m_b;
    logic [7:0] m_data;
    int         m_due, m_cyc, m_ops;
    bit         rec_en;
    int         dut_g[$];

    function automatic bit m_win();
        return (a_r1v && !a_r0v) || (a_r0v && a_r1v && !m_last);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_rvalid = 0; m_last = 1; m_id = 0;
        m_sel = '0; m_a = '0; m_b = '0; m_data = '0;
        m_due = 0; m_cyc = 0; m_ops = 0;
    endtask

    task automatic idle_a();
        a_r0v = 0; a_r1v = 0;
        a_r0s = '0; a_r0a = '0; a_r0b = '0;
        a_r1s = '0; a_r1a = '0; a_r1b = '0;
    endtask

    task automatic step_a();
        bit w, any;
        #1;
        w   = m_win();
        any = a_r0v || a_r1v;
        check("ready0", a_r0rdy, !m_busy && any && !w);
        check("ready1", a_r1rdy, !m_busy && any && w);
        check("busy", a_busy, m_busy);
        check("rsp_valid", a_rsp_valid, m_rvalid);
        check("rsp_id", a_rsp_id, m_id);
        check("rsp_data", a_rsp_data, m_data);
        check("alu_sel", a_alu_sel, m_sel);
        check("alu_a", a_alu_a, m_a);
        check("alu_b", a_alu_b, m_b);
        check("ops_done", a_ops, m_ops);
        if (rec_en && a_r0v && a_r0rdy) dut_g.push_back(0);
        if (rec_en && a_r1v && a_r1rdy) dut_g.push_back(1);
        @(posedge clk);
        m_cyc++;
        if (m_rvalid && a_rsp_ready) begin
            m_rvalid = 0;
            m_busy   = 0;
            if (m_ops < 65535) m_ops++;
        end else if (m_busy && !m_rvalid) begin
            if (m_cyc == m_due) begin
                m_data   = alu_fn(m_sel, m_a, m_b);
                m_rvalid = 1;
            end
        end else if (!m_busy && any) begin
            m_id   = w;
            m_last = w;
            m_busy = 1;
            m_due  = m_cyc + W_A;
            m_sel  = w ? a_r1s : a_r0s;
            m_a    = w ? a_r1a : a_r0a;
            m_b    = w ? a_r1b : a_r0b;
        end
        @(negedge clk);
    endtask

    task automatic reset_a();
        a_rst_n = 0;
        #1;
        check("rst_valid", a_rsp_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ops", a_ops, 0);
        check("rst_alu", {a_alu_sel, a_alu_a, a_alu_b}, 0);
        check("rst_rsp", {a_rsp_id, a_rsp_data}, 0);
        model_reset();
        @(negedge clk);
        a_rst_n = 1;
    endtask

    task automatic op_b(input int k);
        int         t;
        logic [1:0] s;
        logic [3:0] x, y;
        s = 2'($urandom_range(0, 3));
        x = 4'($urandom_range(0, 15));
        y = 4'($urandom_range(0, 15));
        b_r1s = s; b_r1a = x; b_r1b = y; b_r1v = 1; b_rsp_ready = 1;
        t = 0;
        #1;
        while (!b_r1rdy && t < 20) begin
            @(posedge clk); @(negedge clk); #1; t++;
        end
        check("b_accept", b_r1rdy, 1);
        @(posedge clk); @(negedge clk);
        b_r1v = 0;
        t = 0;
        while (!b_rsp_valid && t < 20) begin
            @(posedge clk); @(negedge clk); t++;
        end
        check("b_rsp_valid", b_rsp_valid, 1);
        check("b_rsp", {b_rsp_id, b_rsp_data}, {1'b1, alu_fn(s, x, y)});
        @(posedge clk); @(negedge clk);
        check("b_ops_sat", b_ops, (k < 3) ? k : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 0; b_rst_n = 0; rec_en = 0;
        idle_a();
        a_rsp_ready = 0;
        b_r0v = 0; b_r1v = 0; b_rsp_ready = 0;
        b_r0s = '0; b_r0a = '0; b_r0b = '0; b_r1s = '0; b_r1a = '0; b_r1b = '0;
        model_reset();
        @(negedge clk);
        reset_a();

        // 1: single request, 2+3 = 5.
        a_rsp_ready = 1;
        a_r0v = 1; a_r0s = OP_ADD; a_r0a = 4'd2; a_r0b = 4'd3;
        step_a();
        idle_a();
        step_a();
        check("t1_rsp", {a_rsp_valid, a_rsp_id, a_rsp_data}, {1'b1, 1'b0, 8'd5});
        step_a();
        check("t1_ops", a_ops, 1);
        step_a();

        // 2: continuous contention alternates starting with requester 0.
        reset_a();
        dut_g.delete();
        rec_en = 1;
        a_r0v = 1; a_r0s = OP_MUL; a_r0a = 4'd2;  a_r0b = 4'd3;
        a_r1v = 1; a_r1s = OP_MUL; a_r1a = 4'd15; a_r1b = 4'd15;
        for (int i = 0; i < 40 && dut_g.size() < 4; i++) begin
            step_a();
            if (a_rsp_valid) check("t2_data", a_rsp_data, a_rsp_id ? 8'd225 : 8'd6);
        end
        rec_en = 0;
        check("t2_grants", dut_g.size() >= 4, 1);
        for (int i = 0; i < 4 && i < dut_g.size(); i++) check("t2_order", dut_g[i], i % 2);
        idle_a();
        for (int i = 0; i < 4; i++) step_a();

        // 3: backpressure holds the response and blocks requester 0.
        a_rsp_ready = 0;
        a_r1v = 1; a_r1s = OP_SUB; a_r1a = 4'd2; a_r1b = 4'd3;
        step_a();
        a_r1v = 0;
        a_r0v = 1; a_r0s = OP_ADD; a_r0a = 4'd1; a_r0b = 4'd1;
        for (int i = 0; i < 6; i++) step_a();
        #1;
        check("t3_hold", {a_rsp_valid, a_rsp_id, a_rsp_data}, {1'b1, 1'b1, 8'hFF});
        check("t3_blocked", a_r0rdy, 0);
        a_rsp_ready = 1;
        step_a();
        #1;
        check("t3_r0_next", a_r0rdy, 1);
        step_a();
        idle_a();
        for (int i = 0; i < 3; i++) step_a();

        // 4: reset during EXEC drops the op.
        a_r0v = 1; a_r0s = OP_AND; a_r0a = 4'hA; a_r0b = 4'h6;
        step_a();
        idle_a();
        #1;
        check("t4_in_exec", a_busy, 1);
        reset_a();
        for (int i = 0; i < 5; i++) step_a();
        check("t4_ops", a_ops, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            a_r0v = ($urandom_range(0, 1) == 1);
            a_r1v = ($urandom_range(0, 1) == 1);
            a_r0s = 2'($urandom_range(0, 3)); a_r0a = 4'($urandom_range(0, 15)); a_r0b = 4'($urandom_range(0, 15));
            a_r1s = 2'($urandom_range(0, 3)); a_r1a = 4'($urandom_range(0, 15)); a_r1b = 4'($urandom_range(0, 15));
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            step_a();
        end

        // 5: ALU_WAIT=4, 7*9 = 63, operands stable through EXEC.
        b_rst_n = 1;
        @(negedge clk);
        b_rsp_ready = 1;
        b_r0v = 1; b_r0s = OP_MUL; b_r0a = 4'd7; b_r0b = 4'd9;
        #1;
        check("t5_ready", b_r0rdy, 1);
        @(posedge clk); @(negedge clk);
        b_r0v = 0;
        for (int i = 0; i < 4; i++) begin
            check("t5_alu", {b_alu_sel, b_alu_a, b_alu_b}, {OP_MUL, 4'd7, 4'd9});
            check("t5_exec", {b_busy, b_rsp_valid}, 2'b10);
            @(posedge clk); @(negedge clk);
        end
        check("t5_rsp", {b_rsp_valid, b_rsp_id, b_rsp_data}, {1'b1, 1'b0, 8'd63});
        @(posedge clk); @(negedge clk);
        check("t5_ops", b_ops, 1);

        // 6: 2-bit ops_done saturates at 3.
        b_rst_n = 0;
        #1;
        check("t6_rst_ops", b_ops, 0);
        @(negedge clk);
        b_rst_n = 1;
        for (int k = 1; k <= 5; k++) op_b(k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
